// File: rtl/rp8_io_timer.sv
// rp8 I/O-bus timer/counter: four registers at BAS..BAS+3, prescaled 8-bit counter,
// overflow and compare-match flags driving irq_req.
module rp8_io_timer #(
    parameter logic [5:0] BAS = 6'h30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_wen,
    input  logic       io_ren,
    input  logic [5:0] io_adr,
    input  logic [7:0] io_wdt,
    input  logic [7:0] io_msk,
    output logic [7:0] io_rdt,
    output logic [1:0] irq_req,
    input  logic [1:0] irq_ack
);

    typedef enum logic [1:0] {
        REG_TCCR = 2'd0,
        REG_TCNT = 2'd1,
        REG_OCR  = 2'd2,
        REG_TIFR = 2'd3
    } reg_e;

    logic [5:0] tccr_q, tccr_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] ocr_q,  ocr_d;
    logic [1:0] tifr_q, tifr_d;
    logic [9:0] pre_q,  pre_d;
    logic [7:0] rdt_q,  rdt_d;

    logic       hit;
    reg_e       sel;
    logic       wr_tccr, wr_tcnt, wr_ocr, wr_tifr;
    logic [2:0] cs_q, cs_d;
    logic       run_q, run_d;
    logic       tick;
    logic       ctc;
    logic       tov_set, ocf_set;
    logic [7:0] tccr_mrg;
    logic [7:0] w1c;
    logic [7:0] rd_val;

    function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] wdt,
                                         input logic [7:0] msk);
        return (wdt & msk) | (old & ~msk);
    endfunction

    always_comb begin
        hit     = (io_adr[5:2] == BAS[5:2]);
        sel     = reg_e'(io_adr[1:0]);
        wr_tccr = io_wen && hit && (sel == REG_TCCR);
        wr_tcnt = io_wen && hit && (sel == REG_TCNT);
        wr_ocr  = io_wen && hit && (sel == REG_OCR);
        wr_tifr = io_wen && hit && (sel == REG_TIFR);
    end

    // Prescaler and tick follow the registered CS; PRE clears as soon as the new CS is a stop code.
    always_comb begin
        tccr_mrg = merge({2'b00, tccr_q}, io_wdt, io_msk);
        tccr_d   = wr_tccr ? tccr_mrg[5:0] : tccr_q;
        cs_q     = tccr_q[2:0];
        cs_d     = tccr_d[2:0];
        run_q    = (cs_q != 3'd0) && (cs_q <= 3'd5);
        run_d    = (cs_d != 3'd0) && (cs_d <= 3'd5);
        pre_d    = (run_q && run_d) ? pre_q + 10'd1 : '0;
        case (cs_q)
            3'd1:    tick = 1'b1;
            3'd2:    tick = (pre_q[2:0] == 3'h7);
            3'd3:    tick = (pre_q[5:0] == 6'h3F);
            3'd4:    tick = (pre_q[7:0] == 8'hFF);
            3'd5:    tick = (pre_q == 10'h3FF);
            default: tick = 1'b0;
        endcase
    end

    always_comb begin
        ctc     = tccr_q[3];
        tcnt_d  = tcnt_q;
        tov_set = 1'b0;
        ocf_set = 1'b0;
        if (wr_tcnt) begin
            tcnt_d = merge(tcnt_q, io_wdt, io_msk);
        end else if (tick) begin
            if (ctc && (tcnt_q == ocr_q)) begin
                tcnt_d  = '0;
                ocf_set = 1'b1;
            end else begin
                tcnt_d  = tcnt_q + 8'd1;
                ocf_set = (tcnt_q == ocr_q);
                tov_set = !ctc && (tcnt_q == 8'hFF);
            end
        end
        ocr_d = wr_ocr ? merge(ocr_q, io_wdt, io_msk) : ocr_q;
    end

    // Clears first, then sets, so a set in the same cycle wins.
    always_comb begin
        w1c    = io_wdt & io_msk;
        tifr_d = tifr_q;
        if (wr_tifr) begin
            tifr_d = tifr_d & ~w1c[1:0];
        end
        tifr_d = tifr_d & ~irq_ack;
        tifr_d = tifr_d | {ocf_set, tov_set};
    end

    always_comb begin
        case (sel)
            REG_TCCR: rd_val = {2'b00, tccr_q};
            REG_TCNT: rd_val = tcnt_q;
            REG_OCR:  rd_val = ocr_q;
            default:  rd_val = {6'b0, tifr_q};
        endcase
        rdt_d = rdt_q;
        if (io_ren) begin
            rdt_d = hit ? rd_val : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tccr_q <= '0;
            tcnt_q <= '0;
            ocr_q  <= '0;
            tifr_q <= '0;
            pre_q  <= '0;
            rdt_q  <= '0;
        end else begin
            tccr_q <= tccr_d;
            tcnt_q <= tcnt_d;
            ocr_q  <= ocr_d;
            tifr_q <= tifr_d;
            pre_q  <= pre_d;
            rdt_q  <= rdt_d;
        end
    end

    assign io_rdt  = rdt_q;
    assign irq_req = {tifr_q[1] & tccr_q[5], tifr_q[0] & tccr_q[4]};

endmodule
